// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//                Holds the responder state encoding, the data and byte-enable
//                widths, and a helper that sizes the word index from the
//                array depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Responder sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Number of word-index bits needed to address a power-of-two array
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Synchronous 32-bit word array with per-byte write enables
//                and a registered read port. Contents are not reset.
//  Ports       : clk      - clock
//                i_we     - write strobe (one cycle)
//                i_be     - byte-lane enables for the write
//                i_idx    - word index shared by read and write
//                i_wdata  - write data
//                i_re     - read strobe; o_rdata updates on the next edge
//                o_rdata  - registered read data, held between reads
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side responder for the CPU data-memory port. Accepts
//                one request at a time, inserts WAIT_CYCLES wait states,
//                performs a byte-lane store or a word load on an internal
//                array, then emits a one-cycle response strobe.
//  Options     : DMEM_RESPONDER_ALIGN_CHECK_EN - when defined, a request with
//                addr[1:0] != 0 is rejected: no array access, rsp_err = 1,
//                rsp_rdata = 0, latency unchanged. When undefined rsp_err is
//                always 0 and addr[1:0] is ignored.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready - request handshake
//                req_we, req_addr, req_wdata, req_be - request fields
//                rsp_valid - one-cycle response strobe
//                rsp_rdata - load data (0 for stores/errors), held afterwards
//                rsp_err   - request rejected
//  Latency     : accept at edge T -> rsp_valid high in the cycle after edge
//                T+WAIT_CYCLES+2; next accept possible at edge T+WAIT_CYCLES+3.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,   // power of two, >= 2
    parameter int WAIT_CYCLES = 2      // 0..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W       = idx_width(DEPTH_WORDS);
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;

    // Captured request
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    // Response registers
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [WORD_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_err;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_arr_rdata;
    logic              w_unused_addr;

    assign w_accept = req_valid && req_ready;

    // Upper address bits are dropped, so addresses alias modulo 4*DEPTH_WORDS
    assign w_idx = r_addr[IDX_W+1:2];

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    assign w_err         = (r_addr[1:0] != 2'b00);
    assign w_unused_addr = ^r_addr[WORD_W-1:IDX_W+2];
`else
    assign w_err         = 1'b0;
    assign w_unused_addr = ^{r_addr[WORD_W-1:IDX_W+2], r_addr[1:0]};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        w_arr_we  = 1'b0;
        w_arr_re  = 1'b0;
        case (r_state)
            ST_IDLE:   req_ready = 1'b1;
            ST_ACCESS: begin
                // A rejected request touches neither port of the array
                w_arr_we = r_we  && !w_err;
                w_arr_re = !r_we && !w_err;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;

            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= C_WAIT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // The array's read register is loaded in ACCESS and is stable
            // during RESP; transferring it here makes rsp_valid, rsp_rdata
            // and rsp_err all change together on the edge that leaves RESP.
            if (r_state == ST_RESP) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (r_we || w_err) ? '0 : w_arr_rdata;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // ------------------------------------------------------------------
    // Word array
    // ------------------------------------------------------------------
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (r_be),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .i_re    (w_arr_re),
        .o_rdata (w_arr_rdata)
    );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances share
//                clock and reset: index 0 has WAIT_CYCLES=2, index 1 has
//                WAIT_CYCLES=0. Directed vectors, multi-cycle sequences
//                (held request, reset mid-store) and a randomized phase
//                checked against an array model of the memory.
//  Options     : honours DMEM_RESPONDER_ALIGN_CHECK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int DEPTH = 256;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [2][DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference behaviour: word index from address arithmetic, byte-lane merge
    function automatic void model_op(input int d, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be,
                                     output logic [31:0] rd, output logic err);
        int idx;
        idx = int'((addr / 4) % DEPTH);
        err = ALIGN && ((addr % 4) != 0);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = ref_mem[d][idx];
            end
        end
    endfunction

    // Issue one request and check latency, handshake and response fields
    task automatic do_req(input int d, input string name, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err);
        int lat, first, pulses, n;
        bit ready_bad;
        logic [31:0] got_rdata;
        logic got_err;
        lat = (d == 0) ? W0 : W1;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        req_valid[d] = 1'b1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s/accept_wait", name), 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance: only captured copies may matter
        req_valid[d] = 1'b0;
        req_we[d] = ~we; req_addr[d] = $urandom; req_wdata[d] = $urandom;
        req_be[d] = 4'($urandom);
        first = -1; pulses = 0; ready_bad = 0;
        got_rdata = 'x; got_err = 'x;
        for (int k = 0; k < lat + 6; k++) begin
            @(negedge clk);
            if (rsp_valid[d] === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = k; got_rdata = rsp_rdata[d]; got_err = rsp_err[d];
                end
            end
            if (k < lat + 2 && req_ready[d] !== 1'b0) ready_bad = 1;
            if (k == lat + 2 && req_ready[d] !== 1'b1) ready_bad = 1;
        end
        check($sformatf("%s/latency", name), 32'(first), 32'(lat + 2));
        check($sformatf("%s/pulses", name), 32'(pulses), 32'd1);
        check($sformatf("%s/ready_profile", name), 32'(ready_bad), 32'd0);
        check($sformatf("%s/rdata", name), got_rdata, exp_rdata);
        check($sformatf("%s/err", name), 32'(got_err), 32'(exp_err));
        check($sformatf("%s/rdata_held", name), rsp_rdata[d], exp_rdata);
        check($sformatf("%s/err_idle", name), 32'(rsp_err[d]), 32'd0);
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int pulse_k[$];
        int acc_b, seen;
        logic [31:0] b_rdata, erd;
        logic        eerr, rwe;
        logic [31:0] raddr, rwd;
        logic [3:0]  rbe;
        int          ridx;

        vecs[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0,  "rt_store"};
        vecs[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0,  "rt_load"};
        vecs[2]  = '{0, 1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0,  "bl_full"};
        vecs[3]  = '{0, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0,  "bl_part"};
        vecs[4]  = '{0, 1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0,  "bl_load"};
        vecs[5]  = '{1, 1'b1, 32'h404, 32'h5,        4'hF, 32'h0,        1'b0,  "al_store"};
        vecs[6]  = '{1, 1'b0, 32'h004, 32'h0,        4'h0, 32'h5,        1'b0,  "al_load"};
        vecs[7]  = '{0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0,  "be0_store"};
        vecs[8]  = '{0, 1'b0, 32'h410, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0,  "be0_alias_load"};
        vecs[9]  = '{0, 1'b1, 32'h40,  32'h0,        4'hF, 32'h0,        1'b0,  "mis_init"};
        vecs[10] = '{0, 1'b1, 32'h42,  32'h1234,     4'hF, 32'h0,        ALIGN, "mis_store"};
        vecs[11] = '{0, 1'b0, 32'h40,  32'h0,        4'h0, ALIGN ? 32'h0 : 32'h1234, 1'b0, "mis_load"};
        vecs[12] = '{0, 1'b1, 32'h30,  32'h0,        4'hF, 32'h0,        1'b0,  "rst_init"};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d/ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("reset%0d/rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset%0d/rsp_rdata", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset%0d/rsp_err", d), 32'(rsp_err[d]), 32'd0);
        end

        for (int i = 0; i < 13; i++)
            do_req(vecs[i].d, vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);

        // Held request: B is presented throughout A's service
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h80; req_wdata[0] = 32'hCAFE0001;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        check("held/ready_before_a", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_we[0] = 1'b0; req_addr[0] = 32'h80; req_wdata[0] = 32'h0; req_be[0] = 4'h0;
        acc_b = -1; b_rdata = 'x;
        for (int k = 0; k < 2*W0 + 9; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) begin
                pulse_k.push_back(k);
                if (pulse_k.size() == 2) b_rdata = rsp_rdata[0];
            end
            if (acc_b < 0 && req_ready[0] === 1'b1) begin
                acc_b = k;
                @(posedge clk);
                #1;
                req_valid[0] = 1'b0;
            end
        end
        check("held/accept_b_cycle", 32'(acc_b), 32'(W0 + 2));
        check("held/pulse_count", 32'(pulse_k.size()), 32'd2);
        check("held/pulse_a", 32'((pulse_k.size() > 0) ? pulse_k[0] : -1), 32'(W0 + 2));
        check("held/pulse_b", 32'((pulse_k.size() > 1) ? pulse_k[1] : -1), 32'(2*W0 + 5));
        check("held/b_rdata", b_rdata, 32'hCAFE0001);

        // Reset during the WAIT cycle of a store: never written, no response
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'hFFFFFFFF;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = (rsp_valid[0] === 1'b1) ? 1 : 0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) seen++;
        end
        check("rst_mid/no_response", 32'(seen), 32'd0);
        check("rst_mid/ready", 32'(req_ready[0]), 32'd1);
        do_req(0, "rst_mid_load", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);

        // Randomized phase over words 0..15 with random aliasing upper bits
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                rwd = $urandom;
                model_op(d, 1'b1, 32'(i * 4), rwd, 4'hF, erd, eerr);
                do_req(d, $sformatf("fill%0d_%0d", d, i), 1'b1, 32'(i * 4), rwd, 4'hF, erd, eerr);
            end
        end
        for (int n = 0; n < 120; n++) begin
            int d;
            d     = n % 2;
            ridx  = int'($urandom_range(0, 15));
            raddr = ($urandom & 32'hFFFF_FC00) | 32'(ridx * 4);
            if ($urandom_range(0, 3) == 0) raddr = raddr | 32'($urandom_range(0, 3));
            rwe   = 1'($urandom);
            rwd   = $urandom;
            rbe   = 4'($urandom);
            model_op(d, rwe, raddr, rwd, rbe, erd, eerr);
            do_req(d, $sformatf("rnd%0d", n), rwe, raddr, rwd, rbe, erd, eerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
